// File: rtl/i2c_target_responder.sv
// I2C target responder: synchronized SCL/SDA sampling, 7-bit address match, byte rx/tx handshakes.
// Optional clock stretching while transmit data is unavailable: define I2C_TARGET_CLK_STRETCH_EN.
module i2c_target_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       op,
  output logic       busy,
  output logic       stop_evt
);
  // state     | meaning
  // IDLE      | not addressed, waiting for START
  // ADDR      | shifting in address + R/W
  // ADDR_ACK  | driving ACK for our address
  // WR_BYTE   | receiving a data byte
  // WR_ACK    | driving ACK for a received byte
  // RD_BYTE   | transmitting a data byte
  // RD_ACK    | sampling controller ACK/NACK
  // WAIT_STOP | not ours / NACKed; ignore bus until START or STOP
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  state_t            state;
  logic [SYNC_N-1:0] scl_sync, sda_sync;
  logic              scl_d, sda_d;
  logic [6:0]        shift_reg;
  logic [6:0]        tx_shift;
  logic [2:0]        bit_cnt;
  logic              phase_done;
  logic              rd_nack;
  logic              load_ok;
  logic [7:0]        load_byte;
`ifdef I2C_TARGET_CLK_STRETCH_EN
  logic              scl_hold;
  logic              load_pending;
`endif

  wire scl_s     = scl_sync[SYNC_N-1];
  wire sda_s     = sda_sync[SYNC_N-1];
  wire scl_rise  = scl_s & ~scl_d;
  wire scl_fall  = ~scl_s & scl_d;
  wire start_det = scl_s & scl_d & sda_d & ~sda_s;
  wire stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  wire rd_enter  = scl_fall & phase_done &
                   (((state == ADDR_ACK) & op) | ((state == RD_ACK) & ~rd_nack));

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_N-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_N-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // Without stretching an empty transmit slot is filled with idle-high bits.
  always_comb begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
    load_ok   = tx_valid;
    load_byte = tx_data;
`else
    load_ok   = 1'b1;
    load_byte = tx_valid ? tx_data : 8'hFF;
`endif
  end

`ifdef I2C_TARGET_CLK_STRETCH_EN
  assign scl_oe = scl_hold;
`else
  assign scl_oe = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sda_oe     <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      tx_ready   <= 1'b0;
      op         <= 1'b0;
      busy       <= 1'b0;
      stop_evt   <= 1'b0;
      shift_reg  <= '0;
      tx_shift   <= '1;
      bit_cnt    <= '0;
      phase_done <= 1'b0;
      rd_nack    <= 1'b1;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      scl_hold     <= 1'b0;
      load_pending <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      stop_evt <= 1'b0;
      if (stop_det || start_det) begin
        state      <= stop_det ? IDLE : ADDR;
        busy       <= stop_det ? 1'b0 : busy;
        stop_evt   <= stop_det;
        sda_oe     <= 1'b0;
        bit_cnt    <= '0;
        phase_done <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        scl_hold     <= 1'b0;
        load_pending <= 1'b0;
`endif
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shift_reg <= {shift_reg[5:0], sda_s};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shift_reg == SLAVE_ADDR) begin
                op    <= sda_s;
                busy  <= 1'b1;
                state <= ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end
          end
          // ACK is asserted on the first SCL fall and released on the one after the 9th clock.
          ADDR_ACK, WR_ACK: begin
            if (scl_rise) phase_done <= 1'b1;
            else if (scl_fall) begin
              if (!phase_done) sda_oe <= 1'b1;
              else begin
                sda_oe     <= 1'b0;
                phase_done <= 1'b0;
                state      <= ((state == WR_ACK) || !op) ? WR_BYTE : RD_BYTE;
              end
            end
          end
          WR_BYTE: if (scl_rise) begin
            shift_reg <= {shift_reg[5:0], sda_s};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data  <= {shift_reg, sda_s};
              rx_valid <= 1'b1;
              state    <= WR_ACK;
            end
          end
          RD_BYTE: begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
            if (load_pending) begin
              if (tx_valid) begin
                tx_shift     <= tx_data[6:0];
                sda_oe       <= ~tx_data[7];
                tx_ready     <= 1'b1;
                scl_hold     <= 1'b0;
                load_pending <= 1'b0;
              end
            end else
`endif
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) phase_done <= 1'b1;
            end else if (scl_fall) begin
              if (phase_done) begin
                sda_oe     <= 1'b0;
                phase_done <= 1'b0;
                state      <= RD_ACK;
              end else begin
                sda_oe   <= ~tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b1};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              phase_done <= 1'b1;
              rd_nack    <= sda_s;
            end else if (scl_fall && phase_done) begin
              phase_done <= 1'b0;
              state      <= rd_nack ? WAIT_STOP : RD_BYTE;
            end
          end
          IDLE, WAIT_STOP: ;
          default: state <= IDLE;
        endcase
        // First bit of a read byte goes out on the same SCL fall that ends the preceding ACK.
        if (rd_enter) begin
          if (load_ok) begin
            tx_shift <= load_byte[6:0];
            sda_oe   <= ~load_byte[7];
            tx_ready <= tx_valid;
          end
`ifdef I2C_TARGET_CLK_STRETCH_EN
          else begin
            sda_oe       <= 1'b0;
            scl_hold     <= 1'b1;
            load_pending <= 1'b1;
          end
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: a bit-banged controller on a wired-AND bus model.
module tb_i2c_target_responder;
  localparam int H = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_drv = 1'b1, sda_drv = 1'b1;
  logic       sda_oe, scl_oe, rx_valid, tx_ready, op, busy, stop_evt;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       scl_bus, sda_bus;

  assign scl_bus = scl_drv & ~scl_oe;
  assign sda_bus = sda_drv & ~sda_oe;

  i2c_target_responder #(.SLAVE_ADDR(7'h22), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_bus), .sda_i(sda_bus),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .op(op), .busy(busy), .stop_evt(stop_evt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int rx_cnt = 0, tx_cnt = 0, stop_cnt = 0, both_cnt = 0, oe_cnt = 0, busy_cnt = 0, hold_cnt = 0;
  logic [7:0] rx_log [16];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt % 16] = rx_data;
      rx_cnt++;
    end
    if (tx_ready) tx_cnt++;
    if (stop_evt) stop_cnt++;
    if (rx_valid && tx_ready) both_cnt++;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
    if (scl_oe) hold_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int n = 0;
    while (scl_bus !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (scl_bus !== 1'b1) chk("scl_release_timeout", {31'd0, scl_bus}, 32'd1);
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    wclk(2); sda_drv = b; wclk(H);
    scl_drv = 1'b1; wait_scl_high(); wclk(H/2);
    s = sda_bus; wclk(H/2); scl_drv = 1'b0;
  endtask

  task automatic i2c_start();
    wclk(2); sda_drv = 1'b1; wclk(H);
    scl_drv = 1'b1; wait_scl_high(); wclk(H);
    sda_drv = 1'b0; wclk(H); scl_drv = 1'b0; wclk(H);
  endtask

  task automatic i2c_stop();
    wclk(2); sda_drv = 1'b0; wclk(H);
    scl_drv = 1'b1; wait_scl_high(); wclk(H);
    sda_drv = 1'b1; wclk(H);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(ack_bit, s);
  endtask

  logic       ack;
  logic [7:0] d;
  int b_rx, b_tx, b_stop, b_oe, b_busy, b_hold;

  task automatic snap();
    b_rx = rx_cnt; b_tx = tx_cnt; b_stop = stop_cnt;
    b_oe = oe_cnt; b_busy = busy_cnt; b_hold = hold_cnt;
  endtask

  initial begin
    // Reset state
    wclk(4);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    chk("rst_op", {31'd0, op}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stop_evt", {31'd0, stop_evt}, 32'd0);
    rst = 1'b0;
    wclk(5);

    // Write 0xA5, 0x3C to 0x22
    snap();
    i2c_start();
    write_byte(8'h44, ack); chk("wr_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'hA5, ack); chk("wr_b0_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h3C, ack); chk("wr_b1_ack", {31'd0, ack}, 32'd0);
    chk("wr_op", {31'd0, op}, 32'd0);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    i2c_stop(); wclk(5);
    chk("wr_rx_count", rx_cnt - b_rx, 32'd2);
    chk("wr_rx0", {24'd0, rx_log[b_rx % 16]}, 32'hA5);
    chk("wr_rx1", {24'd0, rx_log[(b_rx + 1) % 16]}, 32'h3C);
    chk("wr_stop_count", stop_cnt - b_stop, 32'd1);
    chk("wr_busy_after_stop", {31'd0, busy}, 32'd0);

    // Read 0x5A (ACK) then 0xC3 (NACK) from 0x22
    snap();
    tx_data = 8'h5A; tx_valid = 1'b1;
    i2c_start();
    write_byte(8'h45, ack); chk("rd_addr_ack", {31'd0, ack}, 32'd0);
    chk("rd_op", {31'd0, op}, 32'd1);
    for (int i = 7; i >= 0; i--) begin
      logic s;
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    tx_data = 8'hC3;
    bit_cycle(1'b0, ack);
    chk("rd_b0", {24'd0, d}, 32'h5A);
    read_byte(1'b1, d); chk("rd_b1", {24'd0, d}, 32'hC3);
    chk("rd_tx_ready_count", tx_cnt - b_tx, 32'd2);
    read_byte(1'b1, d); chk("rd_wait_stop_released", {24'd0, d}, 32'hFF);
    chk("rd_tx_ready_after_nack", tx_cnt - b_tx, 32'd2);
    i2c_stop(); wclk(5);
    chk("rd_stop_count", stop_cnt - b_stop, 32'd1);

    // Address 0x23: never acknowledged, nothing received
    snap();
    i2c_start();
    write_byte(8'h46, ack); chk("miss_addr_nack", {31'd0, ack}, 32'd1);
    write_byte(8'h55, ack); chk("miss_data_nack", {31'd0, ack}, 32'd1);
    i2c_stop(); wclk(5);
    chk("miss_sda_oe_cycles", oe_cnt - b_oe, 32'd0);
    chk("miss_rx_count", rx_cnt - b_rx, 32'd0);
    chk("miss_busy_cycles", busy_cnt - b_busy, 32'd0);

    // Write 0x11, repeated START, read back 0x96
    snap();
    tx_data = 8'h96;
    i2c_start();
    write_byte(8'h44, ack); chk("rs_wr_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h11, ack); chk("rs_wr_ack", {31'd0, ack}, 32'd0);
    chk("rs_op_write", {31'd0, op}, 32'd0);
    chk("rs_rx", {24'd0, rx_log[b_rx % 16]}, 32'h11);
    i2c_start();
    write_byte(8'h45, ack); chk("rs_rd_addr_ack", {31'd0, ack}, 32'd0);
    chk("rs_op_read", {31'd0, op}, 32'd1);
    read_byte(1'b1, d); chk("rs_rd_byte", {24'd0, d}, 32'h96);
    chk("rs_no_stop_between", stop_cnt - b_stop, 32'd0);
    i2c_stop(); wclk(5);

    // Reset during the 4th bit of a read byte (0xE7: that bit is 0, so SDA is driven)
    tx_data = 8'hE7;
    i2c_start();
    write_byte(8'h45, ack); chk("rr_addr_ack", {31'd0, ack}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      logic s;
      bit_cycle(1'b1, s);
    end
    wclk(2); sda_drv = 1'b1; wclk(H);
    chk("rr_bit4_driven", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rr_sda_released", {31'd0, sda_oe}, 32'd0);
    chk("rr_scl_released", {31'd0, scl_oe}, 32'd0);
    wclk(2); rst = 1'b0; wclk(4);
    chk("rr_busy_cleared", {31'd0, busy}, 32'd0);
    snap();
    i2c_start();
    write_byte(8'h44, ack); chk("rr_new_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h77, ack); chk("rr_new_data_ack", {31'd0, ack}, 32'd0);
    i2c_stop(); wclk(5);
    chk("rr_new_rx", {24'd0, rx_log[b_rx % 16]}, 32'h77);

    // Read with no transmit data available for 50+ clk
    snap();
    tx_valid = 1'b0; tx_data = 8'h3C;
    i2c_start();
    write_byte(8'h45, ack); chk("nd_addr_ack", {31'd0, ack}, 32'd0);
`ifdef I2C_TARGET_CLK_STRETCH_EN
    fork
      read_byte(1'b1, d);
      begin
        int n = 0;
        while (scl_oe !== 1'b1 && n < 2000) begin
          @(negedge clk);
          n++;
        end
        wclk(50);
        tx_valid = 1'b1;
      end
    join
    chk("nd_stretch_byte", {24'd0, d}, 32'h3C);
    chk("nd_stretch_len_ge50", {31'd0, (hold_cnt - b_hold) >= 50}, 32'd1);
    chk("nd_tx_ready_count", tx_cnt - b_tx, 32'd1);
`else
    wclk(50);
    read_byte(1'b1, d);
    chk("nd_idle_byte", {24'd0, d}, 32'hFF);
    chk("nd_no_tx_ready", tx_cnt - b_tx, 32'd0);
    chk("nd_no_stretch", hold_cnt - b_hold, 32'd0);
`endif
    i2c_stop(); wclk(5);
    tx_valid = 1'b0;

    chk("rx_tx_overlap", both_cnt, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/i2c_target_responder.md
I2C_TARGET_RESPONDER -- requirements
Module: i2c_target_responder

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h22, 7-bit target address matched after START.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flop depth of the SCL/SDA input synchronizers (minimum 2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port scl_i  input  1  raw bus SCL level.
REQ-006 SHALL have port sda_i  input  1  raw bus SDA level.
REQ-007 SHALL have port sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 SHALL have port scl_oe  output  1  1 = pull SCL low (clock stretch).
REQ-009 SHALL have port rx_data  output  8  last byte written by the controller.
REQ-010 SHALL have port rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-011 SHALL have port tx_data  input  8  next byte to return on a read.
REQ-012 SHALL have port tx_valid  input  1  tx_data available.
REQ-013 SHALL have port tx_ready  output  1  one-cycle strobe; tx_data consumed this cycle.
REQ-014 SHALL have port op  output  1  R/W bit of the current addressed transfer; 0 = write, 1 = read.
REQ-015 SHALL have ports busy (addressed, START to STOP) and stop_evt (one-cycle strobe on STOP), each output 1.

Function
REQ-016 SHALL pass scl_i/sda_i through SYNC_STAGES flops; all edge/event detection uses the synchronized values plus one history flop.
REQ-017 SHALL detect START as synced SDA falling while synced SCL high, and STOP as synced SDA rising while synced SCL high.
REQ-018 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-019 SHALL transition from any state to ADDR on START (repeated START included), and from any state to IDLE on STOP.
REQ-020 SHALL sample SDA MSB-first on each synced SCL rising edge and shift it into an 8-bit register with a 3-bit bit counter.
REQ-021 SHALL change sda_oe only in the cycle after a synced SCL falling edge.
REQ-022 ADDR: after 8 bits, address [7:1] == SLAVE_ADDR SHALL latch op <= bit0 and go to ADDR_ACK; a mismatch SHALL go to WAIT_STOP with SDA never driven.
REQ-023 ADDR_ACK SHALL drive sda_oe=1 for one SCL period, then go to WR_BYTE (op=0) or RD_BYTE (op=1).
REQ-024 WR_BYTE: after the 8th rising edge, rx_data SHALL update and rx_valid SHALL pulse on the next clk; then WR_ACK drives ACK for one SCL period and returns to WR_BYTE.
REQ-025 RD_BYTE SHALL load the transmit shifter from tx_data, pulse tx_ready, and drive sda_oe = ~bit MSB-first for 8 SCL periods.
REQ-026 RD_ACK SHALL release SDA, sample the controller ACK on the SCL rising edge, and go to RD_BYTE on ACK (0) or WAIT_STOP on NACK (1).
REQ-027 When START and STOP are both absent, WAIT_STOP SHALL ignore all SCL/SDA activity.
REQ-028 tx_ready and rx_valid SHALL never assert in the same cycle; at most one tx_ready SHALL occur per read byte.

Reset
REQ-029 On rst=1 the block SHALL enter IDLE with sda_oe=0, scl_oe=0, rx_data=8'h00, rx_valid=0, tx_ready=0, op=0, busy=0, stop_evt=0, and counters and synchronizers cleared to bus-idle (1).
REQ-030 Reset asserted mid-transfer SHALL release SDA and SCL in the cycle after rst is sampled, and the block SHALL then wait for a fresh START.

Configuration
REQ-031 With I2C_TARGET_CLK_STRETCH_EN defined, a read byte load with tx_valid=0 SHALL hold scl_oe=1 (starting after the SCL falling edge) until tx_valid=1, then load and release SCL.
REQ-032 Without I2C_TARGET_CLK_STRETCH_EN, scl_oe SHALL be tied 0, and a load with tx_valid=0 SHALL transmit 8'hFF without pulsing tx_ready.

Verification
REQ-033 Write to 0x22 of bytes 0xA5, 0x3C -> three ACKs driven, two rx_valid pulses with 0xA5 then 0x3C, op=0, stop_evt once.
REQ-034 Read from 0x22 with tx_data 0x5A then 0xC3, controller ACK then NACK -> bus shows 0x5A, 0xC3, two tx_ready pulses, then WAIT_STOP.
REQ-035 Address 0x23 write -> sda_oe stays 0 for the whole transaction, no rx_valid, busy=0.
REQ-036 Write 0x11, repeated START, read -> op changes 0->1, read byte returned, no STOP between.
REQ-037 rst during the 4th bit of a read byte -> sda_oe=0 next cycle, then the following START/address is acknowledged normally.
REQ-038 Read with tx_valid low for 50 clk -> SCL held low 50+ clk with the macro; bus 0xFF and no tx_ready without it.
